// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-look-ahead add/subtract sequencer.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the nibble index; never below one bit so WIDTH=4 still has a register.
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational 4-bit generate/propagate carry-look-ahead adder slice.
module cla_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from g/p and carry_in; no ripple between bits.
    assign c[0] = carry_in;
    assign c[1] = g[0] | (p[0] & carry_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & carry_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & carry_in);

    assign sum       = p ^ c[3:0];
    assign carry_out = c[4];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle add/subtract: one shared 4-bit CLA slice walks the operands LSB nibble first.
// Optional zero/overflow flag outputs are enabled with the CLA_SEQ_FLAGS_EN macro.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef CLA_SEQ_FLAGS_EN
    output logic             zero_flag,
    output logic             ovf_flag,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid holds
    // its payload stable until that edge and never depends combinationally on ready.

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_cout;

    assign slice_a = a_q[NIB_W*int'(idx_q) +: NIB_W];
    assign slice_b = b_q[NIB_W*int'(idx_q) +: NIB_W];

    cla_slice u_slice (
        .a         (slice_a),
        .b         (slice_b),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = sub_flag ? ~src2 : src2;
                    carry_d = sub_flag;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Partial sums build in acc so result stays untouched until completion.
                acc_d[NIB_W*int'(idx_q) +: NIB_W] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_d;
                    cout_d   = slice_cout;
                    zero_d   = (acc_d == '0);
                    ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign dbg_state = state_q;

`ifdef CLA_SEQ_FLAGS_EN
    assign zero_flag = zero_q;
    assign ovf_flag  = ovf_q;
`else
    logic unused_flags;
    assign unused_flags = zero_q ^ ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed scoreboard bench for cla_seq_ctrl at WIDTH=16 (four nibble steps).
module tb_cla_seq_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;
    localparam int EW  = W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         sub_flag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic [1:0]   dbg_state;
`ifdef CLA_SEQ_FLAGS_EN
    logic         zero_flag;
    logic         ovf_flag;
`endif

    // Expected entries are packed as {zero, ovf, carry, result}.
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    cla_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sub_flag  (sub_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
`ifdef CLA_SEQ_FLAGS_EN
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] got_vec();
`ifdef CLA_SEQ_FLAGS_EN
        return {zero_flag, ovf_flag, carry_out, result};
`else
        return {2'b00, carry_out, result};
`endif
    endfunction

    function automatic logic [EW-1:0] exp_mask();
`ifdef CLA_SEQ_FLAGS_EN
        return {EW{1'b1}};
`else
        return {2'b00, {(W+1){1'b1}}};
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [EW-1:0] exp, input bit push, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_in_ready", {31'd0, in_ready}, 32'd1);
        src1     = a;
        src2     = b;
        sub_flag = sub;
        in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic ov_prev;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (lat_q.size() == 0) chk("latency_queue", lat_q.size(), 1);
                    else chk("latency", cyc - lat_q.pop_front(), NIB);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("result_queue", exp_q.size(), 1);
                    end else begin
                        chk("result", 32'(got_vec()), 32'(exp_q[0] & exp_mask()));
                        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                ov_prev = out_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0]  va[4]   = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000};
    logic [W-1:0]  vb[4]   = '{16'h1111, 16'h0001, 16'h0007, 16'h0001};
    logic          vs[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [EW-1:0] vexp[4] = '{{3'b000, 16'h2345}, {3'b101, 16'h0000},
                               {3'b000, 16'hFFFE}, {3'b011, 16'h7FFF}};

    initial begin
        // Reset with a request pending: reset must win.
        rst       = 1'b1;
        in_valid  = 1'b1;
        src1      = 16'hAAAA;
        src2      = 16'h5555;
        sub_flag  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_carry", {31'd0, carry_out}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
`ifdef CLA_SEQ_FLAGS_EN
        chk("reset_flags", {30'd0, zero_flag, ovf_flag}, 32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wins_no_accept", {31'd0, in_ready}, 32'd1);

        // Back-to-back directed vectors, consumer always ready.
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) issue(va[i], vb[i], vs[i], vexp[i], 1'b1, 1'b0);
        drain();

        // Backpressure: hold the result for ten cycles.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(16'h00F0, 16'h0F0F, 1'b0, {3'b000, 16'h0FFF}, 1'b1, 1'b0);
        wait_valid();
        repeat (10) @(negedge clk);
        chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        issue(16'h1234, 16'h1234, 1'b1, {3'b101, 16'h0000}, 1'b1, 1'b0);
        drain();

        // Reset during the second CALC cycle aborts the operation.
        issue(16'hAAAA, 16'h5555, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_carry", {31'd0, carry_out}, 32'd0);
        issue(16'h00FF, 16'h0001, 1'b0, {3'b000, 16'h0100}, 1'b1, 1'b0);
        drain();

        // Inputs change after acceptance and in_valid stays high through DONE.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(16'h4000, 16'h4000, 1'b0, {3'b010, 16'h8000}, 1'b1, 1'b1);
        src1     = 16'hFFFF;
        src2     = 16'hFFFF;
        sub_flag = 1'b1;
        wait_valid();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ignore_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ignore_in_ready", {31'd0, in_ready}, 32'd1);
        drain();

        repeat (8) @(negedge clk);
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_lat_empty", lat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
